// File: rtl/mii_rx_cmd.sv
// mii_rx_cmd: MII 4-bit frame receiver that filters dest MAC/EtherType, checks FCS
// and returns the first 8 payload bytes of each good frame as a command word.
module mii_rx_cmd #(
   parameter logic [47:0] MAC_ADDR  = 48'h02_00_00_00_00_01,
   parameter logic [15:0] ETH_TYPE  = 16'h88B5,
   parameter int          MAX_BYTES = 1518
) (
   input  logic        clk_25Mz,
   input  logic        reset_N,
   input  logic [3:0]  DATA,
   input  logic        RX_DV,
   input  logic        RX_ER,
   output logic [63:0] cmd_word,
   output logic        cmd_valid,
   output logic        check_receive,
   output logic        check_CRC32,
   output logic [15:0] cnt_ok,
   output logic [15:0] cnt_err
);
   typedef enum logic [2:0] {IDLE, PREAMBLE, BODY, DROP, CHECK} state_t;
   state_t state, state_n;
   logic [31:0] crc, crc_n;
   logic        phase, fail, crc_ok, good;
   logic [3:0]  low_nib;
   logic [7:0]  rx_byte;
   logic [10:0] byte_cnt;
   logic [47:0] dest;
   logic [15:0] etype;
   logic [63:0] shadow;

   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ b[i]) ? 32'hEDB88320 : 32'h0);
      return r;
   endfunction

   assign rx_byte = {DATA, low_nib};
   assign crc_n   = crc_step(crc, rx_byte);
   assign crc_ok  = crc == 32'hDEBB20E3;
   assign good    = !fail && !phase && byte_cnt >= 11'd64 && byte_cnt <= 11'(MAX_BYTES) &&
                    (dest == MAC_ADDR || &dest) && etype == ETH_TYPE && crc_ok;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:     state_n = !RX_DV ? IDLE : DATA == 4'h5 ? PREAMBLE : DROP;
         PREAMBLE: state_n = !RX_DV ? CHECK : RX_ER ? DROP : DATA == 4'h5 ? PREAMBLE :
                             DATA == 4'hD ? BODY : DROP;
         BODY:     state_n = !RX_DV ? CHECK : RX_ER ? DROP : BODY;
         DROP:     state_n = RX_DV ? DROP : CHECK;
         default:  state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_25Mz) begin
      if (!reset_N) begin
         state         <= IDLE;
         crc           <= 32'hFFFFFFFF;
         phase         <= 1'b0;
         fail          <= 1'b0;
         low_nib       <= 4'h0;
         byte_cnt      <= 11'd0;
         dest          <= 48'h0;
         etype         <= 16'h0;
         shadow        <= 64'h0;
         cmd_word      <= 64'h0;
         cmd_valid     <= 1'b0;
         check_receive <= 1'b0;
         check_CRC32   <= 1'b0;
         cnt_ok        <= 16'h0;
         cnt_err       <= 16'h0;
      end else begin
         state     <= state_n;
         cmd_valid <= 1'b0;
         // only a frame that leaves BODY cleanly can be judged on its contents
         if (state_n == CHECK) fail <= state != BODY;
         if (state == PREAMBLE && state_n == BODY) begin
            crc      <= 32'hFFFFFFFF;
            phase    <= 1'b0;
            byte_cnt <= 11'd0;
         end
         if (state == BODY && state_n == BODY) begin
            phase <= !phase;
            if (!phase) low_nib <= DATA;
            else begin
               crc      <= crc_n;
               byte_cnt <= &byte_cnt ? byte_cnt : byte_cnt + 11'd1;
               if (byte_cnt < 11'd6) dest <= {dest[39:0], rx_byte};
               if (byte_cnt == 11'd12 || byte_cnt == 11'd13) etype <= {etype[7:0], rx_byte};
               if (byte_cnt >= 11'd14 && byte_cnt <= 11'd21) shadow <= {shadow[55:0], rx_byte};
            end
         end
         if (state == CHECK) begin
            check_receive <= !check_receive;
            cmd_valid     <= good;
            check_CRC32   <= crc_ok;
            if (good) begin
               cmd_word <= shadow;
               cnt_ok   <= &cnt_ok ? cnt_ok : cnt_ok + 16'd1;
            end else cnt_err <= &cnt_err ? cnt_err : cnt_err + 16'd1;
         end
      end
   end
endmodule
